cond_logic_pipe: RTL and testbench

//  Conditional-execution unit for the pipelined core. Sits in the Execute stage.

---
 rtl/cond_logic_pipe_pkg.sv | 32 +++
 rtl/cond_logic_pipe_if.sv | 39 +++
 rtl/cond_logic_pipe_cond_check4.sv | 39 +++
 rtl/cond_logic_pipe.sv | 84 ++++++++
 tb/tb_cond_logic_pipe.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cond_logic_pipe_pkg.sv
// Shared types and flag/field indices for the conditional-execution unit.
// cond_t also serves the single-cycle core through cond_check4.
package cond_logic_pipe_pkg;

  typedef enum logic [3:0] {
    COND_EQ  = 4'h0,
    COND_NE  = 4'h1,
    COND_CS  = 4'h2,
    COND_CC  = 4'h3,
    COND_MI  = 4'h4,
    COND_PL  = 4'h5,
    COND_VS  = 4'h6,
    COND_VC  = 4'h7,
    COND_HI  = 4'h8,
    COND_LS  = 4'h9,
    COND_GE  = 4'hA,
    COND_LT  = 4'hB,
    COND_GT  = 4'hC,
    COND_LE  = 4'hD,
    COND_AL  = 4'hE,
    COND_AL2 = 4'hF
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_logic_pipe_if.sv
// Execute-stage control bundle: decoded instruction controls in, gated
// write/branch controls and the NZCV register out.
interface cond_logic_pipe_if #(
  parameter int COND_W = 4
);
  logic              stall;
  logic              valid_e;
  logic [COND_W-1:0] cond_e;
  logic              pc_src_e;
  logic              reg_write_e;
  logic              mem_write_e;
  logic              no_write_e;
  logic              branch_e;
  logic [1:0]        flag_write_e;
  logic [3:0]        alu_flags;

  logic              pc_src_p;
  logic              reg_write_p;
  logic              mem_write_p;
  logic              branch_taken;
  logic              flush;
  logic              cond_ex;
  logic [3:0]        flags_q;

  modport master (
    output stall, valid_e, cond_e, pc_src_e, reg_write_e, mem_write_e,
           no_write_e, branch_e, flag_write_e, alu_flags,
    input  pc_src_p, reg_write_p, mem_write_p, branch_taken, flush,
           cond_ex, flags_q
  );

  modport slave (
    input  stall, valid_e, cond_e, pc_src_e, reg_write_e, mem_write_e,
           no_write_e, branch_e, flag_write_e, alu_flags,
    output pc_src_p, reg_write_p, mem_write_p, branch_taken, flush,
           cond_ex, flags_q
  );

endinterface

// File: rtl/cond_logic_pipe_cond_check4.sv
// Combinational condition evaluator: 4-bit condition code against NZCV.
// Purely combinational so both the pipelined and single-cycle cores can share it.
module cond_check4
  import cond_logic_pipe_pkg::*;
(
  input  cond_t      cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    cond_ex_o = 1'b1;
    case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = (n == v);
      COND_LT: cond_ex_o = (n != v);
      COND_GT: cond_ex_o = ~z & (n == v);
      COND_LE: cond_ex_o = z | (n != v);
      default: cond_ex_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_logic_pipe.sv
// Execute-stage conditional-execution unit: NZCV register, write/branch gating,
// and a squash counter that drops wrong-path instructions after a taken branch.
module cond_logic_pipe
  import cond_logic_pipe_pkg::*;
#(
  parameter int         FLUSH_DEPTH = 2,
  parameter logic [3:0] FLAGS_RESET = 4'b0000,
  parameter int         COND_W      = 4
) (
  input  logic            clk,
  input  logic            reset,
  cond_logic_pipe_if.slave bus
);

  localparam logic [2:0] SQ_LOAD = 3'(FLUSH_DEPTH);

  logic [3:0] nzcv_q, nzcv_d;
  logic [2:0] sq_cnt_q, sq_cnt_d;

  logic [3:0] cond4;
  logic       cond_ex;
  logic       shadow;
  logic       live;
  logic       go;
  logic       br_taken;

  // Legacy 3-bit codes zero-extend into the 0..7 half, so AL cannot be reached.
  always_comb begin
    cond4 = 4'b0000;
    cond4[COND_W-1:0] = bus.cond_e;
  end

  cond_check4 u_check (
    .cond_i    (cond_t'(cond4)),
    .flags_i   (nzcv_q),
    .cond_ex_o (cond_ex)
  );

  assign shadow   = (sq_cnt_q != 3'd0);
  assign live     = bus.valid_e & ~bus.stall & ~shadow & reset;
  assign go       = live & cond_ex;
  assign br_taken = go & bus.branch_e;

  assign bus.cond_ex      = cond_ex;
  assign bus.flags_q      = nzcv_q;
  assign bus.reg_write_p  = go & bus.reg_write_e & ~bus.no_write_e;
  assign bus.mem_write_p  = go & bus.mem_write_e;
  assign bus.pc_src_p     = go & bus.pc_src_e;
  assign bus.branch_taken = br_taken;
  assign bus.flush        = reset & (br_taken | shadow);

  always_comb begin
    nzcv_d = nzcv_q;
    if (go && bus.flag_write_e[FW_NZ]) begin
      nzcv_d[FLAG_N] = bus.alu_flags[FLAG_N];
      nzcv_d[FLAG_Z] = bus.alu_flags[FLAG_Z];
    end
    if (go && bus.flag_write_e[FW_CV]) begin
      nzcv_d[FLAG_C] = bus.alu_flags[FLAG_C];
      nzcv_d[FLAG_V] = bus.alu_flags[FLAG_V];
    end
  end

  // A branch inside the shadow never reloads: br_taken is already gated by shadow.
  always_comb begin
    sq_cnt_d = sq_cnt_q;
    if (br_taken) begin
      sq_cnt_d = SQ_LOAD;
    end else if (shadow && !bus.stall) begin
      sq_cnt_d = sq_cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      nzcv_q   <= FLAGS_RESET;
      sq_cnt_q <= 3'd0;
    end else begin
      nzcv_q   <= nzcv_d;
      sq_cnt_q <= sq_cnt_d;
    end
  end

endmodule

// File: tb/tb_cond_logic_pipe.sv
// Directed bench for cond_logic_pipe: reset, flag groups, condition table,
// branch shadow, stall inside the shadow and reset during a squash.
module tb_cond_logic_pipe;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  cond_logic_pipe_if #(.COND_W(4)) bus ();

  cond_logic_pipe #(
    .FLUSH_DEPTH (2),
    .FLAGS_RESET (4'b0000),
    .COND_W      (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic instr(input logic v, input logic [3:0] c, input logic pc,
                       input logic rw, input logic mw, input logic nw,
                       input logic br, input logic [1:0] fw, input logic [3:0] alu);
    bus.valid_e      = v;
    bus.cond_e       = c;
    bus.pc_src_e     = pc;
    bus.reg_write_e  = rw;
    bus.mem_write_e  = mw;
    bus.no_write_e   = nw;
    bus.branch_e     = br;
    bus.flag_write_e = fw;
    bus.alu_flags    = alu;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b0;
    bus.stall  = 1'b0;

    // Reset held for two cycles with a live-looking branch on the inputs.
    instr(1, 4'hE, 1, 1, 1, 0, 1, 2'b11, 4'hF);
    sample();
    check("rst_branch", bus.branch_taken, 0);
    check("rst_flush", bus.flush, 0);
    check("rst_reg_write", bus.reg_write_p, 0);
    check("rst_mem_write", bus.mem_write_p, 0);
    step();
    sample();
    check("rst_pc_src", bus.pc_src_p, 0);
    step();
    reset = 1'b1;
    instr(0, 4'hE, 0, 0, 0, 0, 0, 2'b00, 4'h0);
    sample();
    check("rst_flags", bus.flags_q, 4'b0000);
    check("rst_flush_after", bus.flush, 0);
    check("rst_outputs", {bus.pc_src_p, bus.reg_write_p, bus.mem_write_p, bus.branch_taken}, 4'b0000);

    // Flag groups updated independently; compare suppresses reg write.
    instr(1, 4'hE, 0, 1, 1, 1, 0, 2'b10, 4'b0110);
    sample();
    check("cmp_no_write", bus.reg_write_p, 0);
    check("cmp_mem_write", bus.mem_write_p, 1);
    step();
    sample();
    check("flags_nz_only", bus.flags_q, 4'b0100);
    instr(1, 4'hE, 0, 0, 0, 0, 0, 2'b01, 4'b1011);
    step();
    sample();
    check("flags_cv_only", bus.flags_q, 4'b0111);

    // Back-to-back: the NE instr must see Z cleared by the previous instr.
    instr(1, 4'hE, 0, 0, 0, 0, 0, 2'b10, 4'b0000);
    step();
    instr(1, 4'h1, 0, 1, 0, 0, 0, 2'b00, 4'b0100);
    sample();
    check("b2b_flags", bus.flags_q, 4'b0011);
    check("b2b_ne_write", bus.reg_write_p, 1);
    step();

    // Condition table: preload flags with an AL writer, then sweep all codes.
    for (int f = 0; f < 16; f++) begin
      logic [3:0] fv;
      fv = 4'(f);
      instr(1, 4'hE, 0, 0, 0, 0, 0, 2'b11, fv);
      step();
      sample();
      check("preload", bus.flags_q, fv);
      for (int c = 0; c < 16; c++) begin
        logic [3:0] cv;
        logic       exp;
        cv  = 4'(c);
        exp = ref_cond(cv, fv);
        instr(1, cv, 0, 1, 0, 0, 0, 2'b00, ~fv);
        sample();
        check($sformatf("cond_ex c=%0h f=%0h", cv, fv), bus.cond_ex, exp);
        check($sformatf("gated_rw c=%0h f=%0h", cv, fv), bus.reg_write_p, exp);
        step();
      end
    end

    // Taken branch and its two-cycle shadow.
    instr(1, 4'hE, 0, 0, 0, 0, 0, 2'b11, 4'b0100);
    step();
    instr(1, 4'h1, 1, 0, 0, 0, 1, 2'b00, 4'h0);
    sample();
    check("bne_not_taken", bus.branch_taken, 0);
    check("bne_flush", bus.flush, 0);
    check("bne_pc_src", bus.pc_src_p, 0);
    step();
    instr(1, 4'h0, 1, 0, 0, 0, 1, 2'b00, 4'h0);
    sample();
    check("beq_taken", bus.branch_taken, 1);
    check("beq_flush", bus.flush, 1);
    check("beq_pc_src", bus.pc_src_p, 1);
    step();
    instr(1, 4'hE, 0, 1, 1, 0, 0, 2'b11, 4'b0000);
    sample();
    check("shadow1_rw", bus.reg_write_p, 0);
    check("shadow1_mw", bus.mem_write_p, 0);
    check("shadow1_flush", bus.flush, 1);
    step();
    instr(1, 4'hE, 1, 1, 0, 0, 1, 2'b00, 4'h0);
    sample();
    check("shadow2_branch", bus.branch_taken, 0);
    check("shadow2_rw", bus.reg_write_p, 0);
    check("shadow2_flush", bus.flush, 1);
    step();
    instr(1, 4'hE, 0, 1, 0, 0, 0, 2'b00, 4'h0);
    sample();
    check("post_shadow_rw", bus.reg_write_p, 1);
    check("post_shadow_flush", bus.flush, 0);
    check("shadow_flags_kept", bus.flags_q, 4'b0100);
    step();

    // Stall inside the shadow holds the counter.
    instr(1, 4'h0, 1, 0, 0, 0, 1, 2'b00, 4'h0);
    sample();
    check("stall_beq_taken", bus.branch_taken, 1);
    step();
    bus.stall = 1'b1;
    instr(1, 4'hE, 1, 1, 1, 0, 1, 2'b11, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("stall%0d_flush", i), bus.flush, 1);
      check($sformatf("stall%0d_outs", i),
            {bus.pc_src_p, bus.reg_write_p, bus.mem_write_p, bus.branch_taken}, 4'b0000);
      step();
    end
    bus.stall = 1'b0;
    instr(1, 4'hE, 0, 1, 0, 0, 0, 2'b00, 4'h0);
    sample();
    check("unstall1_flush", bus.flush, 1);
    check("unstall1_rw", bus.reg_write_p, 0);
    step();
    sample();
    check("unstall2_flush", bus.flush, 1);
    check("unstall2_rw", bus.reg_write_p, 0);
    step();
    sample();
    check("unstall3_flush", bus.flush, 0);
    check("unstall3_rw", bus.reg_write_p, 1);
    check("stall_flags_kept", bus.flags_q, 4'b0100);
    step();

    // Reset one cycle after a taken branch cancels the squash.
    instr(1, 4'h0, 1, 0, 0, 0, 1, 2'b00, 4'h0);
    sample();
    check("rstsq_taken", bus.branch_taken, 1);
    step();
    reset = 1'b0;
    instr(1, 4'hE, 0, 1, 0, 0, 0, 2'b00, 4'h0);
    sample();
    check("rstsq_low_flush", bus.flush, 0);
    check("rstsq_low_rw", bus.reg_write_p, 0);
    step();
    reset = 1'b1;
    sample();
    check("rstsq_flush", bus.flush, 0);
    check("rstsq_flags", bus.flags_q, 4'b0000);
    check("rstsq_rw", bus.reg_write_p, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
